// File: rtl/axi_lite_addsub_array.sv
// axi_lite_addsub_array
//   AXI4-Lite slave with NUM_CH signed operand pairs and one shared add/sub
//   unit. Software loads OPA/OPB, writes CTRL.start, and a sequencer computes
//   one channel per clock (wrap or signed saturate), then flags STATUS.done
//   and drives irq when CTRL.ie is set.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN  clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address, data, response channels
//   S_AXI_AR* / S_AXI_R*             read address and data channels
//   irq                              level interrupt (done & ie)
// Map: 0x00 CTRL, 0x04 STATUS, channel c at 0x10*(c+1): OPA, OPB, RES, zero.
module axi_lite_addsub_array #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int OP_WIDTH           = 32,
  parameter int NUM_CH             = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  localparam int BLK_W = C_S_AXI_ADDR_WIDTH - 4;
  localparam int CH_W  = 3;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg, ch_next;

  logic                awready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [1:0]          bresp_reg;
  logic [31:0]         rdata_reg;

  logic                ctrl_sub_reg, ctrl_sat_reg, ctrl_ie_reg;
  logic                start_pend_reg, run_sub_reg, run_sat_reg;
  logic                done_reg, done_next;
  logic [NUM_CH-1:0]   ovf_reg, ovf_next;
  logic [OP_WIDTH-1:0] opa_reg [NUM_CH];
  logic [OP_WIDTH-1:0] opb_reg [NUM_CH];
  logic [OP_WIDTH-1:0] res_reg [NUM_CH];

  logic                busy, seq_start;
  logic                wr_en, rd_en, wr_ctrl, wr_status, wr_op_any;
  logic [BLK_W-1:0]    wr_blk, rd_blk;
  logic [1:0]          wr_off, rd_off;
  logic [NUM_CH-1:0]   wr_opa, wr_opb;
  logic [31:0]         rd_mux;
  logic [OP_WIDTH-1:0] a_sel, b_sel, res_val;
  logic [OP_WIDTH:0]   sum_full;
  logic                ovf_now;
  logic                unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] sext(input logic [OP_WIDTH-1:0] v);
    logic signed [OP_WIDTH-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  // Byte-strobe merge against the sign-extended view software reads back.
  function automatic logic [OP_WIDTH-1:0] apply_strb(input logic [OP_WIDTH-1:0] old,
                                                     input logic [31:0] data,
                                                     input logic [3:0] strb);
    logic [31:0] cur;
    cur = sext(old);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
    end
    return cur[OP_WIDTH-1:0];
  endfunction

  // Handshake completes on the edge where the registered ready is high.
  assign wr_en     = awready_reg & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en     = arready_reg & S_AXI_ARVALID;
  assign wr_blk    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
  assign wr_off    = S_AXI_AWADDR[3:2];
  assign rd_blk    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
  assign rd_off    = S_AXI_ARADDR[3:2];
  assign busy      = (state_reg != IDLE);
  assign seq_start = (state_reg == IDLE) && start_pend_reg;
  assign wr_ctrl   = wr_en && (wr_blk == '0) && (wr_off == 2'd0);
  assign wr_status = wr_en && (wr_blk == '0) && (wr_off == 2'd1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_dec
      assign wr_opa[gi] = wr_en && !busy && (wr_blk == BLK_W'(gi + 1)) && (wr_off == 2'd0);
      assign wr_opb[gi] = wr_en && !busy && (wr_blk == BLK_W'(gi + 1)) && (wr_off == 2'd1);
    end
  endgenerate

  // Any operand write, used only to pick SLVERR when it lands while busy.
  always_comb begin
    wr_op_any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && (wr_blk == BLK_W'(c + 1)) && (wr_off[1] == 1'b0)) wr_op_any = 1'b1;
    end
  end

  // Shared arithmetic unit, fed by the channel the sequencer points at.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(ch_reg) == c) begin
        a_sel = opa_reg[c];
        b_sel = opb_reg[c];
      end
    end
    if (run_sub_reg) sum_full = {a_sel[OP_WIDTH-1], a_sel} - {b_sel[OP_WIDTH-1], b_sel};
    else             sum_full = {a_sel[OP_WIDTH-1], a_sel} + {b_sel[OP_WIDTH-1], b_sel};
    // Result fits OP_WIDTH only when the two top bits agree.
    ovf_now = sum_full[OP_WIDTH] ^ sum_full[OP_WIDTH-1];
    res_val = sum_full[OP_WIDTH-1:0];
    if (ovf_now && run_sat_reg) begin
      res_val = sum_full[OP_WIDTH] ? {1'b1, {(OP_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OP_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: if (start_pend_reg) begin
        state_next = RUN;
        ch_next    = '0;
      end
      RUN: begin
        ch_next = ch_reg + CH_W'(1);
        if (ch_reg == CH_W'(NUM_CH - 1)) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
    end
  end

  // Status flags: W1C is applied first so a same-cycle set from the sequencer wins.
  always_comb begin
    ovf_next  = ovf_reg;
    done_next = done_reg;
    if (wr_status && S_AXI_WSTRB[1]) ovf_next = ovf_reg & ~S_AXI_WDATA[8 +: NUM_CH];
    if (wr_status && S_AXI_WSTRB[0] && S_AXI_WDATA[1]) done_next = 1'b0;
    if (seq_start) begin
      ovf_next  = '0;
      done_next = 1'b0;
    end
    if (state_reg == RUN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((32'(ch_reg) == c) && ovf_now) ovf_next[c] = 1'b1;
      end
    end
    if (state_reg == FIN) done_next = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_sub_reg   <= 1'b0;
      ctrl_sat_reg   <= 1'b0;
      ctrl_ie_reg    <= 1'b0;
      start_pend_reg <= 1'b0;
      run_sub_reg    <= 1'b0;
      run_sat_reg    <= 1'b0;
      done_reg       <= 1'b0;
      ovf_reg        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        opa_reg[c] <= '0;
        opb_reg[c] <= '0;
        res_reg[c] <= '0;
      end
    end else begin
      done_reg <= done_next;
      ovf_reg  <= ovf_next;
      if (wr_ctrl && S_AXI_WSTRB[0]) begin
        ctrl_sub_reg <= S_AXI_WDATA[1];
        ctrl_sat_reg <= S_AXI_WDATA[2];
        ctrl_ie_reg  <= S_AXI_WDATA[3];
      end
      // Mode is frozen at launch so CTRL edits mid-run do not disturb it.
      if (seq_start) begin
        start_pend_reg <= 1'b0;
        run_sub_reg    <= ctrl_sub_reg;
        run_sat_reg    <= ctrl_sat_reg;
      end else if (wr_ctrl && S_AXI_WSTRB[0] && S_AXI_WDATA[0] && !busy) begin
        start_pend_reg <= 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_opa[c]) opa_reg[c] <= apply_strb(opa_reg[c], S_AXI_WDATA[31:0], S_AXI_WSTRB[3:0]);
        if (wr_opb[c]) opb_reg[c] <= apply_strb(opb_reg[c], S_AXI_WDATA[31:0], S_AXI_WSTRB[3:0]);
        if ((state_reg == RUN) && (32'(ch_reg) == c)) res_reg[c] <= res_val;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_blk == '0) begin
      case (rd_off)
        2'd0: rd_mux = {28'b0, ctrl_ie_reg, ctrl_sat_reg, ctrl_sub_reg, 1'b0};
        2'd1: begin
          rd_mux[0]             = busy;
          rd_mux[1]             = done_reg;
          rd_mux[2]             = |ovf_reg;
          rd_mux[8 +: NUM_CH]   = ovf_reg;
        end
        default: rd_mux = '0;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_blk == BLK_W'(c + 1)) begin
        case (rd_off)
          2'd0:    rd_mux = sext(opa_reg[c]);
          2'd1:    rd_mux = sext(opb_reg[c]);
          2'd2:    rd_mux = sext(res_reg[c]);
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      awready_reg <= !awready_reg && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_reg;
      if (wr_en) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= (wr_op_any && busy) ? 2'b10 : 2'b00;
      end else if (S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
      arready_reg <= !arready_reg && S_AXI_ARVALID && !rvalid_reg;
      if (rd_en) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = awready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = done_reg & ctrl_ie_reg;

endmodule

// File: tb/tb_axi_lite_addsub_array.sv
// Directed testbench for axi_lite_addsub_array (NUM_CH=4, OP_WIDTH=32).
module tb_axi_lite_addsub_array;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_addsub_array #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7), .OP_WIDTH(32), .NUM_CH(NUM_CH)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] er);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    check("aw_accept", 32'(awready & wready), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    check("bvalid", 32'(bvalid), 32'd1);
    check($sformatf("bresp_%02h", a), 32'(bresp), 32'(er));
    $display("WR addr=0x%02h data=0x%08h strb=0x%h resp=%0d", a, d, s, bresp);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [6:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("ar_accept", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    check("rvalid", 32'(rvalid), 32'd1);
    check("rresp", 32'(rresp), 32'd0);
    d = rdata;
    $display("RD addr=0x%02h data=0x%08h", a, d);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] e);
    logic [31:0] d;
    axi_rd(a, d);
    check(tag, d, e);
  endtask

  task automatic wait_run();
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ok, rises;
    logic prev;
    rst_n = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {24'b0, awready, wready, bvalid, arready, rvalid, irq, bresp},
          32'd0);
    check("rst_r", {rdata[29:0], rresp}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ok = 0;
    repeat (5) begin @(posedge clk); #1; if (!bvalid && !rvalid) ok++; end
    check("idle_no_valid", 32'(ok), 32'd5);
    for (int a = 0; a < 128; a += 4) rd_chk($sformatf("rst_rd_%02h", a), 7'(a), 32'd0);

    // Basic add / sub
    axi_wr(7'h10, 32'd5, 4'hF, 2'b00);
    axi_wr(7'h14, 32'd3, 4'hF, 2'b00);
    axi_wr(7'h00, 32'h1, 4'hF, 2'b00);
    wait_run();
    rd_chk("add_status", 7'h04, 32'h2);
    rd_chk("add_res0", 7'h18, 32'd8);
    rd_chk("ctrl_start_clr", 7'h00, 32'h0);
    axi_wr(7'h00, 32'h3, 4'hF, 2'b00);
    wait_run();
    rd_chk("sub_res0", 7'h18, 32'd2);
    axi_wr(7'h10, 32'd3, 4'hF, 2'b00);
    axi_wr(7'h14, 32'd5, 4'hF, 2'b00);
    axi_wr(7'h00, 32'h3, 4'hF, 2'b00);
    wait_run();
    rd_chk("sub_neg_res0", 7'h18, 32'hFFFF_FFFE);
    rd_chk("sub_neg_status", 7'h04, 32'h2);

    // Overflow: wrap, saturate high, saturate low
    axi_wr(7'h20, 32'h7FFF_FFFF, 4'hF, 2'b00);
    axi_wr(7'h24, 32'h1, 4'hF, 2'b00);
    axi_wr(7'h00, 32'h1, 4'hF, 2'b00);
    wait_run();
    rd_chk("wrap_res1", 7'h28, 32'h8000_0000);
    rd_chk("wrap_status", 7'h04, 32'h206);
    rd_chk("wrap_res0", 7'h18, 32'd8);
    axi_wr(7'h00, 32'h5, 4'hF, 2'b00);
    wait_run();
    rd_chk("sat_hi_res1", 7'h28, 32'h7FFF_FFFF);
    rd_chk("sat_hi_status", 7'h04, 32'h206);
    axi_wr(7'h20, 32'h8000_0000, 4'hF, 2'b00);
    axi_wr(7'h00, 32'h7, 4'hF, 2'b00);
    wait_run();
    rd_chk("sat_lo_res1", 7'h28, 32'h8000_0000);
    rd_chk("sat_lo_res0", 7'h18, 32'hFFFF_FFFE);
    rd_chk("sat_lo_status", 7'h04, 32'h206);

    // W1C of one ovf bit then of done
    axi_wr(7'h04, 32'h200, 4'hF, 2'b00);
    rd_chk("w1c_ovf", 7'h04, 32'h2);
    axi_wr(7'h04, 32'h2, 4'hF, 2'b00);
    rd_chk("w1c_done", 7'h04, 32'h0);

    // Interrupt and START-to-done latency
    axi_wr(7'h00, 32'h9, 4'hF, 2'b00);
    n = 0;
    while (!irq && n < 20) begin @(posedge clk); #1; n++; end
    check("irq_latency", 32'(cyc - acc_cyc), 32'(NUM_CH + 2));
    rd_chk("irq_status", 7'h04, 32'h2);
    rd_chk("irq_ctrl", 7'h00, 32'h8);
    rd_chk("irq_res1", 7'h28, 32'h8000_0001);
    axi_wr(7'h04, 32'h2, 4'hF, 2'b00);
    check("irq_cleared", 32'(irq), 32'd0);

    // Byte strobes and unmapped space
    axi_wr(7'h40, 32'hAABB_CCDD, 4'hF, 2'b00);
    axi_wr(7'h40, 32'h1122_3344, 4'h3, 2'b00);
    rd_chk("strb_lo", 7'h40, 32'hAABB_3344);
    axi_wr(7'h40, 32'h55FF_FFFF, 4'h8, 2'b00);
    rd_chk("strb_hi", 7'h40, 32'h55BB_3344);
    axi_wr(7'h60, 32'hDEAD_BEEF, 4'hF, 2'b00);
    rd_chk("unmapped_rd", 7'h60, 32'h0);
    rd_chk("ch_pad_rd", 7'h1C, 32'h0);
    rd_chk("reg_pad_rd", 7'h08, 32'h0);

    // Operand write while busy is refused
    axi_wr(7'h30, 32'h11, 4'hF, 2'b00);
    axi_wr(7'h00, 32'h1, 4'hF, 2'b00);
    axi_wr(7'h30, 32'h99, 4'hF, 2'b10);
    wait_run();
    rd_chk("busy_opa2", 7'h30, 32'h11);
    rd_chk("busy_res2", 7'h38, 32'h11);

    // Second START during a run is ignored: exactly one done
    axi_wr(7'h00, 32'h9, 4'hF, 2'b00);
    axi_wr(7'h00, 32'h9, 4'hF, 2'b00);
    rises = 0; prev = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (irq && !prev) rises++;
      prev = irq;
    end
    check("done_once", 32'(rises), 32'd1);
    axi_wr(7'h04, 32'h2, 4'hF, 2'b00);
    repeat (15) @(posedge clk);
    #1;
    check("no_rerun_irq", 32'(irq), 32'd0);

    // Write response backpressure
    @(negedge clk);
    awaddr = 7'h60; wdata = '0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    ok = 0;
    repeat (10) begin @(posedge clk); #1; if (bvalid && !awready && !wready) ok++; end
    check("bp_write", 32'(ok), 32'd10);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    check("bp_bvalid_drop", 32'(bvalid), 32'd0);
    bready = 1'b0;

    // Read data backpressure
    @(negedge clk);
    araddr = 7'h18; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    ok = 0;
    repeat (10) begin @(posedge clk); #1; if (rvalid && !arready && rdata == 32'd8) ok++; end
    check("bp_read", 32'(ok), 32'd10);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    check("bp_rvalid_drop", 32'(rvalid), 32'd0);
    rready = 1'b0;

    // Reset mid-run discards everything
    axi_wr(7'h00, 32'h1, 4'hF, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_irq", 32'(irq), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    rd_chk("mid_rst_status", 7'h04, 32'h0);
    for (int c = 0; c < NUM_CH; c++) begin
      rd_chk($sformatf("mid_rst_res%0d", c), 7'(16 * (c + 1) + 8), 32'h0);
    end
    rd_chk("mid_rst_opa0", 7'h10, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_addsub_array.md
Name: axi_lite_addsub_array

Overview:
AXI4-Lite slave peripheral holding NUM_CH independent operand pairs, with a shared arithmetic unit that processes them serially. Software loads operands, sets mode bits and writes START. A sequencer computes one channel per cycle, in add or subtract mode, with wrap or signed-saturate behaviour. It then raises DONE and an optional interrupt. This is the parametrised, multi-channel, status/IRQ-capable generation of the single-pair adder_subtractor peripheral. It sits behind the AXI master VIP in the lab block design.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
C_S_AXI_ADDR_WIDTH, 7, byte address width; must cover (NUM_CH+1)*16 bytes.
OP_WIDTH, 32, operand width; 2..32; operands are signed two's complement.
NUM_CH, 4, number of operand/result channels; 1..7.

Ports:
S_AXI_ACLK input 1 clock
S_AXI_ARESETN input 1 asynchronous active-low reset
S_AXI_AWADDR input C_S_AXI_ADDR_WIDTH write address
S_AXI_AWPROT input 3 ignored
S_AXI_AWVALID input 1 write address valid
S_AXI_AWREADY output 1 write address ready
S_AXI_WDATA input 32 write data
S_AXI_WSTRB input 4 byte strobes
S_AXI_WVALID input 1 write data valid
S_AXI_WREADY output 1 write data ready
S_AXI_BRESP output 2 write response
S_AXI_BVALID output 1 write response valid
S_AXI_BREADY input 1 write response ready
S_AXI_ARADDR input C_S_AXI_ADDR_WIDTH read address
S_AXI_ARPROT input 3 ignored
S_AXI_ARVALID input 1 read address valid
S_AXI_ARREADY output 1 read address ready
S_AXI_RDATA output 32 read data
S_AXI_RRESP output 2 read response
S_AXI_RVALID output 1 read data valid
S_AXI_RREADY input 1 read data ready
irq output 1 level interrupt = STATUS.done & CTRL.ie

Behaviour:
- Reset (asynchronous, ARESETN=0): all registers 0, sequencer IDLE. All READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, irq 0. Asserting reset mid-sequence aborts it; no partial results are kept.
- Register map. Word-aligned; address bits [1:0] ignored.
  - 0x00 CTRL (RW): bit0 start (self-clearing, reads 0), bit1 sub, bit2 sat, bit3 ie.
  - 0x04 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 any_ovf (RO, OR of bits 8+), bits[8+NUM_CH-1:8] per-channel ovf (W1C).
  - Channel c (0..NUM_CH-1) at base 0x10*(c+1): +0 OPA (RW), +4 OPB (RW), +8 RES (RO). +C reads 0.
  - Unmapped addresses read 0 with OKAY; writes to them are dropped with OKAY.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle, only when AWVALID & WVALID & !BVALID. Neither is accepted alone.
  - BVALID is asserted the cycle after acceptance and held until BREADY.
  - WSTRB applied per byte. Only bits [OP_WIDTH-1:0] are stored in OPA/OPB; upper bits read as the sign extension.
  - A write to OPA/OPB while busy=1 is dropped with BRESP=SLVERR (2'b10). All other writes return OKAY.
- Read channel:
  - ARREADY pulses one cycle when ARVALID & !RVALID.
  - RVALID is asserted the next cycle with data captured at acceptance, held until RREADY. RRESP=OKAY.
- Sequencer, states IDLE -> RUN -> FIN -> IDLE:
  - IDLE: a write with CTRL.start=1 loads ch=0, sets busy=1, clears done and all ovf bits, latches sub/sat, then goes to RUN the next cycle.
  - RUN: one channel per cycle. Computes RES[ch] = OPA ± OPB at OP_WIDTH+1 bits. Signed overflow is when the result does not fit OP_WIDTH.
    - wrap (sat=0): low OP_WIDTH bits kept.
    - sat=1: clamp to +2^(OP_WIDTH-1)-1 or -2^(OP_WIDTH-1).
    - The ovf[ch] bit is set on overflow in either mode.
    - RES is sign-extended to 32 bits.
    - After ch=NUM_CH-1, go to FIN.
  - FIN: busy=0, done=1, then IDLE.
  - Latency: START write acceptance to done=1 is NUM_CH+2 cycles.
  - START written while busy is ignored; the other CTRL bits still update but do not affect the running sequence.
- Simultaneous events: a W1C of done in the same cycle as FIN leaves done=1, because set wins. A read of RES during RUN returns the old or new value depending on the cycle; no stalling.

Test Plan:
- Reset, then read every register -> all 0, irq=0; BVALID/RVALID stay 0 until a request is issued.
- Write OPA0=5, OPB0=3, CTRL=0x1 -> after NUM_CH+2 cycles STATUS=0x2, RES0=8. Set sub (CTRL=0x3) -> RES0=2. With OPA0=3, OPB0=5, sub -> RES0=0xFFFFFFFE.
- OP_WIDTH=32: OPA1=0x7FFFFFFF, OPB1=1, add, wrap -> RES1=0x80000000, STATUS bit9 and bit2 set. Same with sat=1 (CTRL=0x5) -> RES1=0x7FFFFFFF. OPA1=0x80000000 minus 1 with sat -> 0x80000000.
- CTRL=0x9 with START -> irq rises with done. Write STATUS=0x2 -> done=0, irq=0. Write STATUS=0x200 -> bit9 cleared.
- During busy: write OPA2 -> BRESP=2'b10, value unchanged. A second START is ignored; done occurs exactly once.
- BREADY/RREADY held low for 10 cycles -> BVALID/RVALID stay high and no new AW/AR is accepted. Assert ARESETN=0 mid-RUN -> busy=0, all RES=0.
